sobel_scheduler: RTL
====================

// Module: sobel_scheduler
// PURPOSE
//  Sequences the Sobel pass over the 150x150 grayscale frame in Buffer port A. Per interior pixel it
//  fetches the 3x3 neighbourhood, presents it to core_sobel, thresholds the result and writes 1 bit to
//  Buffer port B. Started by the camera frame-done pulse; VGA reads port B independently.
// PARAMETERS
//  IMG_W      150  frame width in pixels (>=3)
//  IMG_H      150  frame height in pixels (>=3)
//  ADDR_W     15   buffer address width; IMG_W*IMG_H <= 2**ADDR_W
//  RD_LAT     1    port-A read latency in cycles (>=1)
//  SOBEL_LAT  1    core_sobel latency, kernel_valid cycle to sobel_in valid (>=1)
// PORTS
//  clk           in   1        system clock; all logic on rising edge
//  rst_n         in   1        synchronous, active-low reset
//  start         in   1        1-cycle frame-done pulse; request a pass
//  enable        in   1        1 = start accepted; 0 = start ignored (frozen image)
//  threshold     in   8        edge threshold, unsigned
//  rd_en         out  1        port-A read strobe
//  rd_addr       out  ADDR_W   port-A read address
//  rd_data       in   8        port-A gray data, valid RD_LAT cycles after rd_addr
//  kernel        out  72       p0..p8 row-major, p0 = [7:0] (top-left), p4 = centre, p8 = [71:64]
//  kernel_valid  out  1        1-cycle strobe, kernel stable
//  sobel_in      in   8        core_sobel magnitude
//  wr_en         out  1        port-B write strobe
//  wr_addr       out  ADDR_W   port-B write address
//  wr_data       out  1        edge bit
//  busy          out  1        pass in progress
//  done          out  1        1-cycle pulse, last write of a pass completed
// BEHAVIOUR
//  Reset: all outputs 0, kernel 0; state IDLE; row i=1, col j=1; pending flag cleared.
//    Reset overrides everything, including mid-pass: no further rd_en/wr_en; next pass restarts at (1,1).
//  States: IDLE -> FETCH -> DRAIN -> KICK -> WAIT -> WRITE -> (FETCH | DONE); DONE -> IDLE or FETCH.
//  IDLE: start & enable -> FETCH, busy=1 from the next cycle.
//  FETCH: 9 cycles, k=0..8, r=k/3, c=k%3. rd_en=1, rd_addr=(i-1+r)*IMG_W+(j-1+c).
//    Sample k is registered into kernel slot k at the end of cycle k+RD_LAT counted from FETCH entry.
//  DRAIN: RD_LAT cycles, rd_en=0, final samples captured.
//  KICK: 1 cycle, kernel_valid=1.
//  WAIT: SOBEL_LAT-1 cycles; skipped when SOBEL_LAT=1.
//  WRITE: 1 cycle, wr_en=1, wr_addr=i*IMG_W+j, wr_data=(sobel_in >= threshold).
//    Next: j<IMG_W-2 -> j++; else j=1, i++. After (IMG_H-2, IMG_W-2) -> DONE.
//  DONE: done=1 for 1 cycle. If pending -> clear pending, i=j=1, FETCH, busy stays 1; else IDLE, busy=0.
//  Cycles per pixel: 10+RD_LAT+SOBEL_LAT (12 at defaults).
//    Pass time: (IMG_W-2)*(IMG_H-2)*12 + 1 cycles (done cycle).
//  Start while busy (enable=1): sets pending; any number of starts within one pass gives one extra pass.
//  Start on the same cycle as DONE: counts as pending.
//  enable=0 never aborts a running pass; it only blocks new starts and pending sets.
//  Border pixels (row/col 0, last row/col) are never written.
//  Address arithmetic: unsigned, computed at ADDR_W bits; threshold compare unsigned 8-bit.
//    threshold=0 -> every interior bit 1.
// TESTING
//  Reset: hold rst_n=0 with start=1 -> all outputs 0, busy=0. Release -> IDLE until a start arrives.
//  IMG_W=IMG_H=5, rd_data=address, start pulse -> 9 writes at addrs 6,7,8,11,12,13,16,17,18;
//    first kernel = {0,1,2,5,6,7,10,11,12}; done 108 cycles after busy rises.
//  threshold=40: sobel_in=40 -> wr_data=1; sobel_in=39 -> 0.
//    threshold=0 -> all writes 1; sobel_in=255 with threshold=255 -> 1.
//  3 starts during a pass -> exactly one more pass; its first rd_addr=0 follows the done cycle with
//    busy held 1. enable=0 start -> no activity.
//  rst_n=0 at FETCH k=4 of pixel (2,3) -> no wr_en; next start begins at rd_addr 0 (pixel 1,1).
//  RD_LAT=2, SOBEL_LAT=3 -> 15 cycles per pixel; kernel slots match addresses with no skew.

Source files
------------

// File: rtl/sobel_scheduler_if.sv
// Bundle between the Sobel scheduler and the frame buffer, core_sobel and camera control.
// Latency: none, wiring only.
// Backpressure: none; every transfer is a strobe timed by the scheduler.
// Signals: start/enable/threshold/busy/done (pass control), rd_en/rd_addr/rd_data (buffer port A),
//   kernel/kernel_valid/sobel_in (core_sobel), wr_en/wr_addr/wr_data (buffer port B).
// Modports: master = scheduler side, slave = buffer/core_sobel/camera side.
interface sobel_scheduler_if #(
  parameter int ADDR_W = 15
);
  logic              start;
  logic              enable;
  logic [7:0]        threshold;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [71:0]       kernel;
  logic              kernel_valid;
  logic [7:0]        sobel_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;

  modport master (
    input  start, enable, threshold, rd_data, sobel_in,
    output busy, done, rd_en, rd_addr, kernel, kernel_valid, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, enable, threshold, rd_data, sobel_in,
    input  busy, done, rd_en, rd_addr, kernel, kernel_valid, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/sobel_scheduler.sv
// Walks every interior pixel of the frame: fetch 3x3 from port A, kick core_sobel, write edge bit to port B.
// Latency: 10+RD_LAT+SOBEL_LAT cycles per pixel; done pulses one cycle after the last write.
// Backpressure: none; starts arriving mid-pass collapse into a single pending re-run.
// Ports: clk, rst_n (synchronous, active low); bus (master) carries start/enable/threshold in,
//   busy/done out, port-A read strobe/address/data, kernel/kernel_valid out with sobel_in back,
//   and the port-B write strobe/address/data.
module sobel_scheduler #(
  parameter int IMG_W     = 150,
  parameter int IMG_H     = 150,
  parameter int ADDR_W    = 15,
  parameter int RD_LAT    = 1,
  parameter int SOBEL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  sobel_scheduler_if.master bus
);

  localparam int DIM_MAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CNT_W   = $clog2(DIM_MAX + 1);
  localparam int PH_W    = $clog2(RD_LAT + 10);
  localparam int WT_W    = $clog2(SOBEL_LAT + 1);

  localparam logic [ADDR_W-1:0] ROW1   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW2   = ADDR_W'(2 * IMG_W);
  localparam logic [CNT_W-1:0]  LAST_I = CNT_W'(IMG_H - 2);
  localparam logic [CNT_W-1:0]  LAST_J = CNT_W'(IMG_W - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_KICK, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  row_i, col_j;
  // Address of the top-left neighbour of the current pixel, (i-1)*IMG_W + (j-1).
  logic [ADDR_W-1:0] tl_addr;
  // Cycles since FETCH entry; runs through FETCH and DRAIN and drives sample capture.
  logic [PH_W-1:0]   phase;
  logic [PH_W-1:0]   slot;
  logic [1:0]        fr, fc;
  logic [WT_W-1:0]   wait_cnt;
  logic              pending;
  logic [8:0][7:0]   kernel_q;
  logic              start_ok;
  logic              last_pix;
  logic              capture;
  logic [ADDR_W-1:0] row_off;

  logic              rd_en_c, kv_c, wr_en_c, wr_data_c, busy_c, done_c;
  logic [ADDR_W-1:0] rd_addr_c, wr_addr_c;

  assign start_ok = bus.start & bus.enable;
  assign last_pix = (row_i == LAST_I) && (col_j == LAST_J);
  assign slot     = phase - PH_W'(RD_LAT);
  assign capture  = ((state == S_FETCH) || (state == S_DRAIN)) && (phase >= PH_W'(RD_LAT));

  always_comb begin
    row_off = '0;
    if (fr == 2'd1)      row_off = ROW1;
    else if (fr == 2'd2) row_off = ROW2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rd_en_c   = 1'b0;
    rd_addr_c = '0;
    kv_c      = 1'b0;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    wr_data_c = 1'b0;
    busy_c    = (state != S_IDLE);
    done_c    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_ok) state_nx = S_FETCH;
      end
      S_FETCH: begin
        rd_en_c   = 1'b1;
        rd_addr_c = tl_addr + row_off + ADDR_W'(fc);
        if (phase == PH_W'(8)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (phase == PH_W'(8 + RD_LAT)) state_nx = S_KICK;
      end
      S_KICK: begin
        kv_c     = 1'b1;
        state_nx = (SOBEL_LAT > 1) ? S_WAIT : S_WRITE;
      end
      S_WAIT: begin
        if (wait_cnt == WT_W'(SOBEL_LAT - 2)) state_nx = S_WRITE;
      end
      S_WRITE: begin
        wr_en_c   = 1'b1;
        wr_addr_c = tl_addr + ROW1 + ADDR_W'(1);
        wr_data_c = (bus.sobel_in >= bus.threshold);
        state_nx  = last_pix ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done_c = 1'b1;
        // A start landing on the done cycle is treated exactly like a pending one.
        state_nx = (pending | start_ok) ? S_FETCH : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_i    <= CNT_W'(1);
      col_j    <= CNT_W'(1);
      tl_addr  <= '0;
      phase    <= '0;
      fr       <= '0;
      fc       <= '0;
      wait_cnt <= '0;
      pending  <= 1'b0;
      kernel_q <= '0;
    end else begin
      if ((state == S_FETCH) || (state == S_DRAIN)) phase <= phase + PH_W'(1);
      else                                          phase <= '0;

      if (state == S_FETCH) begin
        if (fc == 2'd2) begin
          fc <= '0;
          fr <= fr + 2'd1;
        end else begin
          fc <= fc + 2'd1;
        end
      end else begin
        fr <= '0;
        fc <= '0;
      end

      // Sample k arrives RD_LAT cycles after its address, so slot = phase - RD_LAT.
      if (capture) begin
        for (int s = 0; s < 9; s++) begin
          if (slot == PH_W'(s)) kernel_q[s] <= bus.rd_data;
        end
      end

      if (state == S_WAIT) wait_cnt <= wait_cnt + WT_W'(1);
      else                 wait_cnt <= '0;

      if (state == S_WRITE) begin
        if (col_j < LAST_J) begin
          col_j   <= col_j + CNT_W'(1);
          tl_addr <= tl_addr + ADDR_W'(1);
        end else begin
          // Row wrap: top-left moves from column IMG_W-3 of one row to column 0 of the next.
          col_j   <= CNT_W'(1);
          row_i   <= row_i + CNT_W'(1);
          tl_addr <= tl_addr + ADDR_W'(3);
        end
      end

      if (state == S_DONE) begin
        row_i   <= CNT_W'(1);
        col_j   <= CNT_W'(1);
        tl_addr <= '0;
        pending <= 1'b0;
      end else if ((state != S_IDLE) && start_ok) begin
        pending <= 1'b1;
      end
    end
  end

  assign bus.rd_en        = rd_en_c;
  assign bus.rd_addr      = rd_addr_c;
  assign bus.kernel       = kernel_q;
  assign bus.kernel_valid = kv_c;
  assign bus.wr_en        = wr_en_c;
  assign bus.wr_addr      = wr_addr_c;
  assign bus.wr_data      = wr_data_c;
  assign bus.busy         = busy_c;
  assign bus.done         = done_c;

endmodule
